// File: rtl/accum_pkg.sv
// Shared definitions for the accum_bank accumulator array.
// Contents:
//   state_t  - controller states (idle, accepting beats, holding results)
//   sat_max  - largest signed value that fits in w bits
//   sat_min  - smallest signed value that fits in w bits
package accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 32'd1));
    endfunction

endpackage

// File: rtl/accum_lane.sv
// One signed accumulator lane.
// Ports:
//   clock, reset_n  - clock and synchronous active-low reset
//   clear           - zero the accumulator and the sticky overflow flag
//   en              - fold data into the accumulator this cycle
//   sub             - 0: acc += data, 1: acc -= data
//   data            - signed WIDTH-bit operand
//   acc             - signed ACC_W-bit running result
//   overflow        - sticky flag, set when any update left the ACC_W range
module accum_lane
    import accum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ACC_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    sub,
    input  logic signed [WIDTH-1:0] data,
    output logic signed [ACC_W-1:0] acc,
    output logic                    overflow
);

    localparam logic signed [63:0]      MAX64_C = sat_max(ACC_W);
    localparam logic signed [63:0]      MIN64_C = sat_min(ACC_W);
    localparam logic signed [ACC_W-1:0] MAX_C   = MAX64_C[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] MIN_C   = MIN64_C[ACC_W-1:0];

    logic signed [ACC_W-1:0] acc_r;
    logic                    ovf_r;
    logic signed [ACC_W:0]   ext_in_s;
    logic signed [ACC_W:0]   ext_acc_s;
    logic signed [ACC_W:0]   sum_s;
    logic                    ovf_s;
    logic signed [ACC_W-1:0] next_s;

    // Widen both operands by one bit so the sum can never lose its true sign.
    always_comb begin
        ext_in_s  = {{(ACC_W + 1 - WIDTH){data[WIDTH-1]}}, data};
        ext_acc_s = {acc_r[ACC_W-1], acc_r};
        if (sub) begin
            sum_s = ext_acc_s - ext_in_s;
        end else begin
            sum_s = ext_acc_s + ext_in_s;
        end
        // The widened sum is out of ACC_W range exactly when its top two bits differ;
        // the top bit then tells which bound was crossed.
        ovf_s = (sum_s[ACC_W] != sum_s[ACC_W-1]);
        if (!ovf_s) begin
            next_s = sum_s[ACC_W-1:0];
        end else if (SATURATE != 0) begin
            next_s = sum_s[ACC_W] ? MIN_C : MAX_C;
        end else begin
            next_s = sum_s[ACC_W-1:0];
        end
    end

    // Accumulator register and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (en) begin
            acc_r <= next_s;
            ovf_r <= ovf_r | ovf_s;
        end else begin
            acc_r <= acc_r;
            ovf_r <= ovf_r;
        end
    end

    assign acc      = acc_r;
    assign overflow = ovf_r;

endmodule

// File: rtl/accum_bank.sv
// Bank of LANES independent signed accumulators sharing one control FSM.
// A start pulse clears all lanes and arms a run of len beats; every accepted
// beat updates all lanes at once. After the last beat the results are held
// on out_data until the consumer takes them.
// Ports:
//   clock, reset_n       - clock and synchronous active-low reset
//   start, len, sub      - begin a run of len beats, add (0) or subtract (1)
//   in_valid/in_ready    - input beat handshake, in_data packs LANES operands
//   out_valid/out_ready  - result handshake, out_data packs LANES results
//   overflow             - per-lane sticky overflow since the last start
//   busy                 - a run is in progress or results are held
module accum_bank
    import accum_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int WIDTH    = 8,
    parameter int ACC_W    = 16,
    parameter int CNT_W    = 10,
    parameter int SATURATE = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       len,
    input  logic                   sub,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic [LANES-1:0]       overflow,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W - 1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] remaining_r;
    logic             sub_r;
    logic             start_fire_s;
    logic             beat_s;

    // Next-state logic; a start taken from HOLD behaves exactly like one from IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        start_fire_s = 1'b0;
        beat_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_fire_s = 1'b1;
                    state_nxt_s  = (len == CNT_ZERO_C) ? ST_HOLD : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                beat_s = in_valid;
                if (in_valid && (remaining_r == CNT_ONE_C)) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (out_ready && start) begin
                    start_fire_s = 1'b1;
                    state_nxt_s  = (len == CNT_ZERO_C) ? ST_HOLD : ST_RUN;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, remaining-beat counter and latched direction.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            remaining_r <= CNT_ZERO_C;
            sub_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (start_fire_s) begin
                remaining_r <= len;
                sub_r       <= sub;
            end else if (beat_s) begin
                remaining_r <= remaining_r - CNT_ONE_C;
                sub_r       <= sub_r;
            end else begin
                remaining_r <= remaining_r;
                sub_r       <= sub_r;
            end
        end
    end

    assign in_ready  = (state_r == ST_RUN);
    assign out_valid = (state_r == ST_HOLD);
    assign busy      = (state_r != ST_IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        accum_lane #(
            .WIDTH    (WIDTH),
            .ACC_W    (ACC_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .clear    (start_fire_s),
            .en       (beat_s),
            .sub      (sub_r),
            .data     (in_data[g*WIDTH +: WIDTH]),
            .acc      (out_data[g*ACC_W +: ACC_W]),
            .overflow (overflow[g])
        );
    end

endmodule

// File: tb/tb_accum_bank.sv
// Testbench for accum_bank: a saturating and a wrapping instance share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_accum_bank;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 10;
    localparam int MAXV  = 32767;
    localparam int MINV  = -32768;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic [CNT_W-1:0]       len;
    logic                   sub;
    logic                   in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_ready;

    logic                   in_ready_s, out_valid_s, busy_s;
    logic [LANES*ACC_W-1:0] out_data_s;
    logic [LANES-1:0]       overflow_s;
    logic                   in_ready_w, out_valid_w, busy_w;
    logic [LANES*ACC_W-1:0] out_data_w;
    logic [LANES-1:0]       overflow_w;

    accum_bank #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1)) dut_sat (
        .clock(clock), .reset_n(reset_n), .start(start), .len(len), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .overflow(overflow_s), .busy(busy_s)
    );

    accum_bank #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .start(start), .len(len), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .overflow(overflow_w), .busy(busy_w)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lane_val(input logic [LANES*ACC_W-1:0] v, input int i);
        logic signed [ACC_W-1:0] t;
        t = v[i*ACC_W +: ACC_W];
        return int'(t);
    endfunction

    function automatic logic [LANES*WIDTH-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {WIDTH'(l3), WIDTH'(l2), WIDTH'(l1), WIDTH'(l0)};
    endfunction

    // ---------------- behavioural model ----------------
    bit running, holding, m_sub, m_go;
    int m_rem, m_v, m_t;
    int m_sat[LANES];
    int m_wrap[LANES];
    bit m_ovs[LANES];
    bit m_ovw[LANES];

    task automatic model_clear();
        for (int i = 0; i < LANES; i++) begin
            m_sat[i] = 0; m_wrap[i] = 0; m_ovs[i] = 1'b0; m_ovw[i] = 1'b0;
        end
    endtask

    initial begin
        running = 1'b0; holding = 1'b0; m_sub = 1'b0; m_rem = 0;
        model_clear();
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            running = 1'b0; holding = 1'b0; m_sub = 1'b0; m_rem = 0;
            model_clear();
        end else if (running) begin
            if (in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    m_v = int'($signed(in_data[i*WIDTH +: WIDTH]));
                    if (m_sub) m_v = -m_v;
                    m_t = m_sat[i] + m_v;
                    if (m_t > MAXV) begin m_ovs[i] = 1'b1; m_t = MAXV; end
                    if (m_t < MINV) begin m_ovs[i] = 1'b1; m_t = MINV; end
                    m_sat[i] = m_t;
                    m_t = m_wrap[i] + m_v;
                    if (m_t > MAXV) begin m_ovw[i] = 1'b1; m_t = m_t - 65536; end
                    if (m_t < MINV) begin m_ovw[i] = 1'b1; m_t = m_t + 65536; end
                    m_wrap[i] = m_t;
                end
                m_rem = m_rem - 1;
                if (m_rem == 0) begin running = 1'b0; holding = 1'b1; end
            end
        end else begin
            m_go = start && (!holding || out_ready);
            if (holding && out_ready) holding = 1'b0;
            if (m_go) begin
                model_clear();
                m_sub = sub;
                if (len == 0) holding = 1'b1;
                else begin running = 1'b1; m_rem = int'(len); end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("in_ready_sat",  in_ready_s,  running);
            check("out_valid_sat", out_valid_s, holding);
            check("busy_sat",      busy_s,      running | holding);
            check("in_ready_wrap",  in_ready_w,  running);
            check("out_valid_wrap", out_valid_w, holding);
            check("busy_wrap",      busy_w,      running | holding);
            for (int i = 0; i < LANES; i++) begin
                check($sformatf("lane%0d_sat", i),  lane_val(out_data_s, i), m_sat[i]);
                check($sformatf("lane%0d_wrap", i), lane_val(out_data_w, i), m_wrap[i]);
                check($sformatf("ovf%0d_sat", i),   overflow_s[i], m_ovs[i]);
                check($sformatf("ovf%0d_wrap", i),  overflow_w[i], m_ovw[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int l, input bit s, input bit rdy);
        start = 1'b1; len = CNT_W'(l); sub = s; out_ready = rdy;
        tick();
        start = 1'b0; out_ready = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; len = '0; sub = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        check("rst_busy", busy_s, 0);
        check("rst_out_valid", out_valid_s, 0);
        check("rst_data", out_data_s, 0);
        check("rst_ovf", overflow_s, 0);

        // Plain accumulation.
        pulse_start(3, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data = pack(5, 1, 1, 1);  tick();
        in_data = pack(-2, 1, 1, 1); tick();
        in_data = pack(7, 1, 1, 1);  tick();
        in_valid = 1'b0;
        check("t1_out_valid", out_valid_s, 1);
        check("t1_lane0", lane_val(out_data_s, 0), 10);
        for (int i = 1; i < LANES; i++) check($sformatf("t1_lane%0d", i), lane_val(out_data_s, i), 3);
        check("t1_ovf", overflow_s, 0);
        release_result();
        check("t1_idle", busy_s, 0);

        // Subtraction and a held result.
        pulse_start(3, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data = pack(0, 1, 0, 0); tick();
        in_data = pack(0, 2, 0, 0); tick();
        in_data = pack(0, 3, 0, 0); tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("t2_lane1", lane_val(out_data_s, 1), -6);
            check("t2_out_valid", out_valid_s, 1);
            check("t2_in_ready", in_ready_s, 0);
            tick();
        end
        release_result();

        // Long run: saturation versus wrap on lane 0.
        pulse_start(300, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int b = 0; b < 300; b++) begin
            in_data = pack(127, int'($urandom_range(6)) - 3, int'($urandom_range(6)) - 3, int'($urandom_range(6)) - 3);
            tick();
        end
        in_valid = 1'b0;
        check("t3_sat_lane0", lane_val(out_data_s, 0), 32767);
        check("t3_wrap_lane0", lane_val(out_data_w, 0), -27436);
        check("t3_sat_ovf", overflow_s, 4'b0001);
        check("t3_wrap_ovf", overflow_w, 4'b0001);

        // Zero-length run straight from HOLD, then back-to-back run.
        pulse_start(0, 1'b0, 1'b1);
        check("t5_out_valid", out_valid_s, 1);
        check("t5_ovf_cleared", overflow_s, 0);
        check("t5_zero", out_data_s, 0);
        pulse_start(2, 1'b0, 1'b1);
        check("t5_in_ready", in_ready_s, 1);
        check("t5_out_valid_low", out_valid_s, 0);
        in_valid = 1'b1;
        in_data = pack(3, 4, 5, 6);     tick();
        in_data = pack(-1, -1, -1, -1); tick();
        in_valid = 1'b0;
        check("t5_lane0", lane_val(out_data_s, 0), 2);
        check("t5_lane3", lane_val(out_data_s, 3), 5);
        release_result();

        // Gaps in in_valid: beats only on cycles 0, 3, 4 and 9.
        pulse_start(4, 1'b0, 1'b0);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 10; c++) begin
                in_valid = (c == 0) || (c == 3) || (c == 4) || (c == 9);
                if (in_valid) begin
                    k++;
                    in_data = pack(10 * k, 1, 2, 3);
                end else begin
                    in_data = LANES*WIDTH'($urandom());
                end
                tick();
                if (c == 8) check("t4_not_done", out_valid_s, 0);
            end
        end
        in_valid = 1'b0;
        check("t4_out_valid", out_valid_s, 1);
        check("t4_lane0", lane_val(out_data_s, 0), 100);
        check("t4_lane3", lane_val(out_data_s, 3), 12);
        release_result();

        // Reset in the middle of a run.
        pulse_start(5, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data = pack(50, 60, 70, 80); tick();
        in_data = pack(50, 60, 70, 80); tick();
        in_valid = 1'b0;
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("t6_busy", busy_s, 0);
        check("t6_out_valid", out_valid_s, 0);
        check("t6_data", out_data_s, 0);
        check("t6_ovf", overflow_s, 0);
        pulse_start(2, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data = pack(1, 2, 3, 4); tick();
        in_data = pack(1, 2, 3, 4); tick();
        in_valid = 1'b0;
        check("t6_lane0", lane_val(out_data_s, 0), -2);
        check("t6_lane3", lane_val(out_data_s, 3), -8);
        release_result();

        // Randomised traffic, including ignored starts and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            reset_n   = ($urandom_range(499) != 0);
            start     = ($urandom_range(5) == 0);
            len       = ($urandom_range(9) == 0) ? CNT_W'($urandom_range(600, 260)) : CNT_W'($urandom_range(12));
            sub       = $urandom_range(1) == 1;
            in_valid  = ($urandom_range(3) != 0);
            in_data   = pack(int'($urandom_range(127, 90)), int'($urandom()), int'($urandom()), int'($urandom()));
            out_ready = ($urandom_range(2) == 0);
            tick();
        end
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accum_bank.md
Name: accum_bank

Overview:
Multi-lane, parametrised successor to the single accumulator primitive. It holds LANES independent signed accumulators that are cleared and armed by a start pulse. Each lane sums or subtracts exactly len input beats, accepted through a valid/ready handshake, with optional saturation and sticky per-lane overflow flags. The block then presents all lane results on a held valid/ready output port. It sits between the operand streamers and the result writeback in the matrix/vector datapath, for example for dot-product row reduction.

Parameters:
LANES, 4, number of independent accumulator lanes
WIDTH, 8, signed input width per lane
ACC_W, 16, signed accumulator width per lane (ACC_W >= WIDTH)
CNT_W, 10, width of the beat-count input len
SATURATE, 1, 1 = clamp to signed ACC_W range on overflow, 0 = two's-complement wrap

Ports:
clock  in  1  single clock, all state updates on posedge
reset_n  in  1  synchronous, active-low reset
start  in  1  pulse: clear lanes, latch len and sub, begin a run
len  in  CNT_W  number of input beats to accumulate (unsigned)
sub  in  1  0 = acc += in, 1 = acc -= in; latched at start
in_valid  in  1  input beat valid
in_ready  out  1  block accepts a beat this cycle
in_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH], signed
out_valid  out  1  results available
out_ready  in  1  consumer accepts results
out_data  out  LANES*ACC_W  lane i at [i*ACC_W +: ACC_W], signed
overflow  out  LANES  sticky per-lane overflow since last start
busy  out  1  high in RUN or HOLD

Behaviour:
- Reset (reset_n low at posedge): state IDLE, all accumulators 0, remaining count 0, sub latch 0, overflow 0, out_valid 0. Reset has priority over every other input, including mid-RUN and mid-HOLD.
- States: IDLE, RUN, HOLD. Combinational outputs:
  - in_ready = (state == RUN).
  - out_valid = (state == HOLD).
  - busy = (state != IDLE).
  - out_data is driven directly from the accumulator registers.
- IDLE:
  - start with len > 0: accumulators <= 0, overflow <= 0, remaining <= len, latch sub, go to RUN.
  - start with len == 0: accumulators <= 0, overflow <= 0, go to HOLD. Zero result is valid the next cycle.
- RUN:
  - A beat is accepted when in_valid && in_ready.
  - Each accepted beat updates every lane in the same cycle: acc[i] <= f(acc[i] +/- sign-extended in[i]).
  - Each accepted beat decrements remaining.
  - When the beat is accepted with remaining == 1, go to HOLD. out_valid rises the cycle after the last accepted beat (1-cycle latency).
  - Cycles with in_valid low change nothing.
  - start is ignored in RUN.
- HOLD:
  - out_data and overflow stay stable; in_ready is 0.
  - out_ready high → IDLE.
  - out_ready && start in the same cycle → behave as the IDLE start case, giving back-to-back runs with no idle cycle.
  - start without out_ready is ignored.
- Arithmetic:
  - Compute in ACC_W+1 bits; the result overflows if it lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On overflow, overflow[i] <= 1 (sticky until the next start).
  - SATURATE=1: clamp to the nearest bound. Once saturated, subsequent beats continue from the clamped value.
  - SATURATE=0: keep the low ACC_W bits.
- Lanes are fully independent; one lane overflowing does not affect the others.

Decomposition:
- Shared package accum_pkg holds:
  - the state enum typedef (IDLE, RUN, HOLD);
  - helper functions sat_max(ACC_W) and sat_min(ACC_W), or equivalent constants.
- One sub-module, accum_lane:
  - contents: one lane's accumulator register, sign extension, add/sub, overflow detect, saturate/wrap, sticky flag;
  - parameters: WIDTH, ACC_W, SATURATE;
  - control inputs: clear, en, sub.
- accum_bank contains the FSM and the beat counter, and generates LANES instances of accum_lane.

Test Plan:
1. Default params, start len=3 sub=0; lane0 beats 5, -2, 7, other lanes 1 each → one cycle after 3rd beat: out_valid=1, lane0=10, lanes1-3=3, overflow=0.
2. start len=3 sub=1; lane1 beats 1, 2, 3 → lane1 = -6; out_ready held low 5 cycles → out_data constant, in_ready=0, out_valid stays 1.
3. SATURATE=1, len=300, lane0 = 127 every beat → lane0 = 32767, overflow[0]=1, other lanes unaffected; repeat with SATURATE=0 → lane0 = -27436, overflow[0]=1.
4. in_valid toggled randomly during len=4 run (e.g. valid on cycles 0, 3, 4, 9) → exactly 4 beats summed; out_valid one cycle after cycle-9 beat.
5. start len=0 → out_valid next cycle, all lanes 0; in HOLD assert out_ready && start(len=2) same cycle → new RUN immediately, previous overflow cleared.
6. reset_n low for one cycle mid-RUN (after 2 of 5 beats) → next cycle IDLE, busy=0, out_valid=0, all lanes 0, overflow 0; subsequent start runs normally.
